// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: per-source gateways, priority/threshold selection, claim/complete handshake.
// Optional IRQ_EDGE_EN: edge-triggered sources with a one-deep deferred edge per source.
module irq_arbiter #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  irq_src,
  output logic              irq_o,
  input  logic              claim_req,
  output logic              claim_valid,
  output logic [4:0]        claim_id,
  input  logic              complete_req,
  input  logic [4:0]        complete_id,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata
);

  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_INFLIGHT} gw_state_t;

  gw_state_t         gw [N_SRC];
  logic [PRIO_W-1:0] prio [N_SRC];
  logic [N_SRC-1:0]  enable;
  logic [PRIO_W-1:0] threshold;

  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  inflight;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  trig;
  logic [N_SRC-1:0]  claim_hit;
  logic [N_SRC-1:0]  complete_hit;
  logic [4:0]        win_id;
  logic [PRIO_W-1:0] win_prio;
  logic              any_elig;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata;

`ifdef IRQ_EDGE_EN
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] deferred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= '0;
    else        src_q <= irq_src;
  end

  assign trig = irq_src & ~src_q;
`else
  assign trig = irq_src;
`endif

  always_comb begin
    pending  = '0;
    inflight = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pending[k]  = (gw[k] == GW_PENDING);
      inflight[k] = (gw[k] == GW_INFLIGHT);
    end
  end

  // Ascending scan with strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    eligible = '0;
    win_id   = '0;
    win_prio = '0;
    any_elig = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      eligible[k] = pending[k] & enable[k] & (prio[k] > threshold);
      if (eligible[k]) any_elig = 1'b1;
      if (eligible[k] && (prio[k] > win_prio)) begin
        win_prio = prio[k];
        win_id   = 5'(k + 1);
      end
    end
  end

  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int k = 0; k < N_SRC; k++) begin
      claim_hit[k]    = claim_req && (win_id == 5'(k + 1));
      complete_hit[k] = complete_req && (complete_id == 5'(k + 1)) && inflight[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SRC; k++) gw[k] <= GW_IDLE;
`ifdef IRQ_EDGE_EN
      deferred <= '0;
`endif
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        case (gw[k])
          GW_IDLE:    if (trig[k]) gw[k] <= GW_PENDING;
          GW_PENDING: if (claim_hit[k]) gw[k] <= GW_INFLIGHT;
          GW_INFLIGHT: begin
`ifdef IRQ_EDGE_EN
            // An edge arriving with the completion counts as deferred.
            if (complete_hit[k]) begin
              gw[k]       <= (deferred[k] | trig[k]) ? GW_PENDING : GW_IDLE;
              deferred[k] <= 1'b0;
            end else if (trig[k]) begin
              deferred[k] <= 1'b1;
            end
`else
            if (complete_hit[k]) gw[k] <= GW_IDLE;
`endif
          end
          default: gw[k] <= GW_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SRC; k++) prio[k] <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        5'h10:        enable    <= cfg_wdata[N_SRC-1:0];
        5'h11:        threshold <= cfg_wdata[PRIO_W-1:0];
        5'h12, 5'h13: ;
        default: begin
          for (int k = 0; k < N_SRC; k++)
            if (cfg_addr == 5'(k)) prio[k] <= cfg_wdata[PRIO_W-1:0];
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      5'h10: cfg_rdata[N_SRC-1:0]  = enable;
      5'h11: cfg_rdata[PRIO_W-1:0] = threshold;
      5'h12: cfg_rdata[N_SRC-1:0]  = pending;
      5'h13: cfg_rdata[N_SRC-1:0]  = inflight;
      default: begin
        for (int k = 0; k < N_SRC; k++)
          if (cfg_addr == 5'(k)) cfg_rdata[PRIO_W-1:0] = prio[k];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o       <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
    end else begin
      irq_o       <= any_elig;
      claim_valid <= claim_req;
      claim_id    <= claim_req ? win_id : 5'd0;
    end
  end

endmodule
